imem_loader: RTL and testbench

Runtime program loader for the single-cycle MIPS core. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them sequentially into instruction memory from word address 0. It holds the core in reset while loading and releases it only after the checksum matches. This replaces file-based image loading on silicon and in FPGA builds; it sits between the host byte link and the imem write port.

---
 rtl/imem_loader.sv | 167 ++++++++++++++++
 tb/tb_imem_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles big-endian words, writes them into imem
// from address 0 and releases the core only after the XOR checksum matches.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_reset_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

  state_e              state_q;
  logic [7:0]          len_hi_q;
  logic [15:0]         len_q;
  logic [ADDR_W-1:0]   word_idx_q;
  logic [1:0]          byte_idx_q;
  logic [31:0]         shift_q;
  logic [7:0]          csum_q;
  logic                in_ready_q;
  logic                imem_we_q;
  logic [ADDR_W-1:0]   imem_addr_q;
  logic [31:0]         imem_wdata_q;
  logic                cpu_reset_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  // Handshake: a byte moves on a rising edge where in_valid_i && in_ready_o;
  // in_ready_o is high in every loading state, so the link is never stalled.
  logic        accept;
  logic [15:0] len_in;
  logic [31:0] word_d;
  logic        last_word;

  assign accept    = in_valid_i & in_ready_q;
  assign len_in    = {len_hi_q, in_data_i};
  assign word_d    = {shift_q[23:0], in_data_i};
  assign last_word = ((17'(word_idx_q) + 17'd1) == {1'b0, len_q});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      len_hi_q     <= '0;
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      shift_q      <= '0;
      csum_q       <= '0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            state_q     <= S_LEN_HI;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_reset_q <= 1'b1;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            csum_q      <= '0;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len_hi_q <= in_data_i;
            state_q  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len_q <= len_in;
            if ({1'b0, len_in} > DEPTH) begin
              state_q    <= S_ERR;
              err_q      <= 1'b1;
              busy_q     <= 1'b0;
              in_ready_q <= 1'b0;
            end else if (len_in == 16'd0) begin
              state_q <= S_CSUM;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            shift_q    <= word_d;
            csum_q     <= csum_q ^ in_data_i;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= word_idx_q;
              imem_wdata_q <= word_d;
              // The index stops at the last word, so N == 2^ADDR_W never wraps it.
              if (last_word) begin
                state_q <= S_CSUM;
              end else begin
                word_idx_q <= word_idx_q + 1'b1;
              end
            end
          end
        end
        S_CSUM: begin
          if (accept) begin
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
            if (in_data_i == csum_q) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign cpu_reset_o  = cpu_reset_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives byte images over the handshake and
// checks imem writes, status flags and core reset against hand-computed values.
module tb_imem_loader;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        state;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .in_ready_o   (in_ready),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .cpu_reset_o  (cpu_reset),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic [39:0] exp_q[$];
  logic [39:0] got_q[$];
  int          got_cyc[$];
  logic [31:0] img[0:255];

  // Write monitor: samples the imem port mid-cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      got_q.push_back({imem_addr, imem_wdata});
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit thr);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      if (!thr || $urandom_range(1, 0) == 1) break;
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
  endtask

  task automatic end_stream();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic logic [7:0] calc_csum(input int n);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < n; i++)
      c = c ^ img[i][31:24] ^ img[i][23:16] ^ img[i][15:8] ^ img[i][7:0];
    return c;
  endfunction

  task automatic build_exp(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back({8'(i), img[i]});
  endtask

  task automatic run_load(input int n, input logic [7:0] csum, input bit thr);
    logic [15:0] len = 16'(n);
    got_q.delete();
    got_cyc.delete();
    start_pulse();
    send_byte(len[15:8], thr);
    send_byte(len[7:0], thr);
    for (int i = 0; i < n; i++) begin
      send_byte(img[i][31:24], thr);
      send_byte(img[i][23:16], thr);
      send_byte(img[i][15:8], thr);
      send_byte(img[i][7:0], thr);
    end
    send_byte(csum, thr);
    end_stream();
  endtask

  task automatic check_writes(input string tag, input bit spaced);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_word"}, 64'(got_q[i]), 64'(exp_q[i]));
    if (spaced)
      for (int i = 1; i < got_cyc.size(); i++)
        chk({tag, "_spacing"}, 64'(got_cyc[i] - got_cyc[i-1]), 64'd4);
  endtask

  initial begin
    img[0] = 32'h20010005;
    img[1] = 32'h20020007;
    img[2] = 32'hAC020007;

    // Reset held for two cycles, then released.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_imem_we", 64'(imem_we), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_state", 64'(state), 64'd0);
    repeat (3) @(negedge clk);
    chk("rst_no_writes", 64'(got_q.size()), 64'd0);

    // start at edge k: busy/in_ready high from cycle k+1.
    start_pulse();
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;

    // Happy path; checksum 0x24 ^ 0x25 ^ 0xA9 = 0xA8.
    build_exp(3);
    run_load(3, 8'hA8, 1'b0);
    check_writes("happy", 1'b1);
    chk("happy_done", 64'(done), 64'd1);
    chk("happy_cpu_reset", 64'(cpu_reset), 64'd0);
    chk("happy_busy", 64'(busy), 64'd0);
    chk("happy_in_ready", 64'(in_ready), 64'd0);
    chk("happy_err", 64'(err), 64'd0);
    repeat (3) @(negedge clk);
    chk("happy_done_sticky", 64'(done), 64'd1);

    // Throttled link.
    run_load(3, 8'hA8, 1'b1);
    check_writes("throttle", 1'b0);
    chk("throttle_done", 64'(done), 64'd1);
    chk("throttle_cpu_reset", 64'(cpu_reset), 64'd0);

    // Bad checksum: words still land, then err.
    run_load(3, 8'hA9, 1'b0);
    check_writes("badcsum", 1'b1);
    chk("badcsum_err", 64'(err), 64'd1);
    chk("badcsum_done", 64'(done), 64'd0);
    chk("badcsum_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("badcsum_busy", 64'(busy), 64'd0);

    // N = 257: error right after LEN_LO, no writes.
    got_q.delete();
    start_pulse();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    end_stream();
    chk("len257_err", 64'(err), 64'd1);
    chk("len257_busy", 64'(busy), 64'd0);
    chk("len257_in_ready", 64'(in_ready), 64'd0);
    chk("len257_cpu_reset", 64'(cpu_reset), 64'd1);
    repeat (2) @(negedge clk);
    chk("len257_no_writes", 64'(got_q.size()), 64'd0);

    // N = 0 with checksum 0x00.
    exp_q.delete();
    run_load(0, 8'h00, 1'b0);
    check_writes("len0", 1'b0);
    chk("len0_done", 64'(done), 64'd1);
    chk("len0_err", 64'(err), 64'd0);
    chk("len0_cpu_reset", 64'(cpu_reset), 64'd0);

    // N = 256: full memory, last write at address 255.
    for (int i = 3; i < 256; i++)
      img[i] = {8'(i), ~8'(i), 8'(i) ^ 8'h5A, 8'hC3};
    build_exp(256);
    run_load(256, calc_csum(256), 1'b0);
    check_writes("len256", 1'b1);
    chk("len256_last_addr", 64'(got_q.size() > 0 ? got_q[got_q.size()-1][39:32] : 8'hxx), 64'd255);
    chk("len256_done", 64'(done), 64'd1);

    // Asynchronous reset after 6 data bytes.
    got_q.delete();
    start_pulse();
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(img[0][31-8*i -: 8], 1'b0);
    send_byte(img[1][31:24], 1'b0);
    send_byte(img[1][23:16], 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_state", 64'(state), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("midrst_imem_addr", 64'(imem_addr), 64'd0);
    chk("midrst_imem_wdata", 64'(imem_wdata), 64'd0);
    chk("midrst_prior_write", 64'(got_q.size()), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    build_exp(3);
    run_load(3, 8'hA8, 1'b0);
    check_writes("postrst", 1'b1);
    chk("postrst_done", 64'(done), 64'd1);
    chk("postrst_cpu_reset", 64'(cpu_reset), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
